// File: rtl/video_timing_gen.sv
`default_nettype none
// video_timing_gen: raster timing generator (counters, syncs, strobes, line prefetch request).
// Revision 1.0

module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 32,
  parameter int H_BACK   = 266,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 21,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int LEAD     = 16,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int HB      = $clog2(H_TOTAL),
  localparam int VB      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic          active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          h_start,
  output logic          v_start,
  output logic          line_req,
  output logic          frame_end,
  output logic [HB-1:0] x,
  output logic [VB-1:0] y
);

  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int LR_H     = H_TOTAL - LEAD;

  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_size
    $error("video_timing_gen: ACTIVE and SYNC parameters must be non-zero");
  end
  if (LEAD < 1 || LEAD > H_TOTAL - 1) begin : g_bad_lead
    $error("video_timing_gen: LEAD must lie in 1..H_TOTAL-1");
  end

  logic [HB-1:0] h_q, h_d;
  logic [VB-1:0] v_q, v_d;
  logic [31:0]   h_ext, v_ext;
  logic          h_last, v_last;

  logic          active_q, active_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          h_start_q, h_start_d;
  logic          v_start_q, v_start_d;
  logic          line_req_q, line_req_d;
  logic          frame_end_q, frame_end_d;
  logic [HB-1:0] x_q, x_d;
  logic [VB-1:0] y_q, y_d;

  // Widen counters so comparisons against integer geometry never truncate
  // (e.g. a sync window ending exactly at H_TOTAL when the back porch is 0).
  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);

  always_comb begin
    h_last      = (h_ext == 32'(H_TOTAL - 1));
    v_last      = (v_ext == 32'(V_TOTAL - 1));
    h_d         = h_last ? '0 : h_q + HB'(1);
    v_d         = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + VB'(1);
    end
    active_d    = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
    h_sync_d    = ((h_ext >= 32'(HS_START)) && (h_ext < 32'(HS_END))) ? H_POL : ~H_POL;
    v_sync_d    = ((v_ext >= 32'(VS_START)) && (v_ext < 32'(VS_END))) ? V_POL : ~V_POL;
    h_start_d   = (h_ext == 32'd0) && (v_ext < 32'(V_ACTIVE));
    v_start_d   = (h_ext == 32'd0) && (v_ext == 32'd0);
    frame_end_d = h_last && v_last;
    // The last line of the frame requests line 0 of the following frame.
    line_req_d  = (h_ext == 32'(LR_H)) && (((v_ext + 32'd1) < 32'(V_ACTIVE)) || v_last);
    x_d         = h_q;
    y_d         = v_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      active_q    <= 1'b0;
      h_sync_q    <= ~H_POL;
      v_sync_q    <= ~V_POL;
      h_start_q   <= 1'b0;
      v_start_q   <= 1'b0;
      line_req_q  <= 1'b0;
      frame_end_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else if (ce) begin
      h_q         <= h_d;
      v_q         <= v_d;
      active_q    <= active_d;
      h_sync_q    <= h_sync_d;
      v_sync_q    <= v_sync_d;
      h_start_q   <= h_start_d;
      v_start_q   <= v_start_d;
      line_req_q  <= line_req_d;
      frame_end_q <= frame_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign active    = active_q;
  assign h_sync    = h_sync_q;
  assign v_sync    = v_sync_q;
  assign h_start   = h_start_q;
  assign v_start   = v_start_q;
  assign line_req  = line_req_q;
  assign frame_end = frame_end_q;
  assign x         = x_q;
  assign y         = y_q;

endmodule

`default_nettype wire

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 48, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 32, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 266, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE / V_FRONT / V_SYNC / V_BACK, defaults 600 / 3 / 6 / 21, the same quantities in lines.
REQ-006 SHALL have parameter H_POL, default 1, asserted level of h_sync.
REQ-007 SHALL have parameter V_POL, default 1, asserted level of v_sync.
REQ-008 SHALL have parameter LEAD, default 16, cycles by which line_req precedes h_start; legal range 1..H_TOTAL-1.
REQ-009 SHALL have ports: clk input 1, sole clock.
REQ-010 SHALL have ports: reset input 1, synchronous, active-high.
REQ-011 SHALL have ports: ce input 1, pixel clock enable.
REQ-012 SHALL have ports: active output 1, pixel is visible.
REQ-013 SHALL have ports: h_sync and v_sync, both output 1, sync at the polarity given by H_POL / V_POL.
REQ-014 SHALL have ports: h_start output 1, first pixel of a visible line.
REQ-015 SHALL have ports: v_start output 1, first pixel of a frame.
REQ-016 SHALL have ports: line_req output 1, fetch request for the next visible line.
REQ-017 SHALL have ports: frame_end output 1, last pixel of a frame.
REQ-018 SHALL have ports: x output HB, and y output VB, current counter values.

Function
REQ-019 SHALL define H_TOTAL as the sum of the H_* parameters and V_TOTAL as the sum of the V_* parameters.
REQ-020 SHALL set HB = $clog2(H_TOTAL) and VB = $clog2(V_TOTAL).
REQ-021 SHALL keep internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
REQ-022 SHALL, on ce=1, advance h each cycle; h SHALL wrap to 0 after H_TOTAL-1, and v SHALL increment on that wrap and wrap to 0 after V_TOTAL-1.
REQ-023 SHALL, on ce=0, hold counters and all outputs; single-cycle pulses remain asserted and are not re-issued.
REQ-024 SHALL register all outputs, each reflecting the counter values of the previous ce cycle (latency 1).
REQ-025 SHALL assert active iff h<H_ACTIVE and v<V_ACTIVE.
REQ-026 SHALL drive h_sync = H_POL iff H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, else ~H_POL; this applies on every line, blanking lines included.
REQ-027 SHALL drive v_sync = V_POL iff V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, else ~V_POL, for the whole line.
REQ-028 SHALL assert h_start iff h==0 and v<V_ACTIVE.
REQ-029 SHALL assert v_start iff h==0 and v==0.
REQ-030 SHALL assert frame_end iff h==H_TOTAL-1 and v==V_TOTAL-1.
REQ-031 SHALL assert line_req iff h==H_TOTAL-LEAD and the next line is visible, i.e. v+1<V_ACTIVE, or v==V_TOTAL-1, in which case the request is for line 0 of the next frame.
REQ-032 SHALL therefore issue exactly V_ACTIVE line_req pulses per frame, each exactly LEAD ce-cycles before the matching h_start.
REQ-033 SHALL drive x=h and y=v, with no clamping in blanking.
REQ-034 SHALL reject illegal parameters at elaboration: any ACTIVE or SYNC value of 0, or LEAD outside 1..H_TOTAL-1.

Reset
REQ-035 SHALL, while reset=1 and regardless of ce, set h=v=0, x=y=0, active=0, h_start=v_start=line_req=frame_end=0, h_sync=~H_POL and v_sync=~V_POL.
REQ-036 SHALL, in the first ce cycle after reset falls, register h=0,v=0, so outputs on the next edge show active=1, h_start=1, v_start=1.
REQ-037 SHALL abandon any frame in progress when reset is asserted mid-frame; no partial pulses remain.

Verification
REQ-038 SHALL use test parameters H=8/2/3/3 (H_TOTAL 16) and V=4/1/2/1 (V_TOTAL 8), LEAD=4, ce=1.
REQ-039 Full frame, release reset -> 128 cycles per frame, 32 active cycles, 4 h_start, 1 v_start, 1 frame_end, then repeats identically.
REQ-040 Polarity, H_POL=0 and V_POL=1 -> h_sync low for cycles 10..12 of every line; v_sync high for lines 5..6; inactive levels otherwise and during reset.
REQ-041 Line request -> line_req at h=12 of lines 0,1,2 and 7; never on lines 3..6; each followed 4 cycles later by h_start.
REQ-042 Clock enable, ce toggled 1,0 pseudo-randomly -> output sequence sampled on ce cycles identical to the ce=1 run; outputs frozen while ce=0.
REQ-043 Reset mid-frame at v=2,h=5 -> reset-state outputs the next cycle; after release, v_start occurs exactly one ce cycle after release; no stale line_req.
REQ-044 Wrap-around, LEAD=15 -> line_req at h=1 of lines 0..2 and of line 7, with no missing or duplicate requests across the frame boundary.
